// File: rtl/sap_pkg.sv
// -----------------------------------------------------------------------------
// sap_pkg
// Shared definitions for the 8-bit accumulator CPU datapath:
//   - control-word bit positions (the control unit's bit order)
//   - the two fixed fetch control words
//   - opcode values carried in IR[7:4]
//   - bus source selector and a helper that counts active bus drivers
// No ports; imported with "import sap_pkg::*;".
// -----------------------------------------------------------------------------
package sap_pkg;

  // Control-word bit positions. The CTRL_ prefix keeps these apart from the
  // opcode names, since SUB and HLT exist in both sets.
  localparam int CTRL_HLT      = 15;
  localparam int CTRL_MARWA    = 14;
  localparam int CTRL_RAMWA    = 13;
  localparam int CTRL_RAMOA    = 12;
  localparam int CTRL_INREGOA  = 11;
  localparam int CTRL_INREGWA  = 10;
  localparam int CTRL_AWA      = 9;
  localparam int CTRL_AOA      = 8;
  localparam int CTRL_SUMOUT   = 7;
  localparam int CTRL_SUB      = 6;
  localparam int CTRL_BWA      = 5;
  localparam int CTRL_OUTREGWA = 4;
  localparam int CTRL_PCINC    = 3;
  localparam int CTRL_PCOE     = 2;
  localparam int CTRL_PCJMP    = 1;
  localparam int CTRL_FLAGSIN  = 0;

  // Fetch step 0: MAR <- PC.  Fetch step 1: IR <- RAM[MAR], PC <- PC+1.
  localparam logic [15:0] FETCH0 = 16'h4004;
  localparam logic [15:0] FETCH1 = 16'h1408;

  // Opcodes as they appear in IR[7:4].
  localparam logic [3:0] OP_LDA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_STA = 4'd4;
  localparam logic [3:0] OP_LDI = 4'd5;
  localparam logic [3:0] OP_JMP = 4'd6;
  localparam logic [3:0] OP_JC  = 4'd7;
  localparam logic [3:0] OP_JZ  = 4'd8;
  localparam logic [3:0] OP_OUT = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  // Which source won the bus this cycle.
  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_RAM,
    SRC_IR,
    SRC_A,
    SRC_ALU,
    SRC_PC
  } bus_src_t;

  // Number of bus drivers requested by a control word; two or more is
  // contention.
  function automatic logic [2:0] driver_count(input logic [15:0] c);
    return {2'b00, c[CTRL_RAMOA]} + {2'b00, c[CTRL_INREGOA]} +
           {2'b00, c[CTRL_AOA]}   + {2'b00, c[CTRL_SUMOUT]}   +
           {2'b00, c[CTRL_PCOE]};
  endfunction

endpackage

// File: rtl/sap_datapath_if.sv
// -----------------------------------------------------------------------------
// sap_datapath_if
// Bundle between the control unit / program loader (master) and the
// datapath (slave).
//   ctrl       : 16-bit control word
//   ld_en      : program-load enable
//   ld_addr    : program-load RAM address
//   ld_data    : program-load RAM data
//   ir_op      : IR[7:4] opcode back to the control unit
//   flag_c     : latched carry flag
//   flag_z     : latched zero flag
//   out_val    : output register
//   out_strobe : one-cycle pulse after each output-register write
//   halted     : sticky halt indicator
//   bus_err    : sticky bus-contention indicator
//   bus_dbg    : current bus value
// -----------------------------------------------------------------------------
interface sap_datapath_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [15:0]       ctrl;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [3:0]        ir_op;
  logic              flag_c;
  logic              flag_z;
  logic [DATA_W-1:0] out_val;
  logic              out_strobe;
  logic              halted;
  logic              bus_err;
  logic [DATA_W-1:0] bus_dbg;

  modport master (
    output ctrl, ld_en, ld_addr, ld_data,
    input  ir_op, flag_c, flag_z, out_val, out_strobe, halted, bus_err, bus_dbg
  );

  modport slave (
    input  ctrl, ld_en, ld_addr, ld_data,
    output ir_op, flag_c, flag_z, out_val, out_strobe, halted, bus_err, bus_dbg
  );
endinterface

// File: rtl/sap_alu.sv
// -----------------------------------------------------------------------------
// sap_alu
// Combinational DATA_W adder/subtractor.
//   a, b  : operands (A and B registers)
//   sub   : 0 = a+b, 1 = a+~b+1 (carry=1 means no borrow)
//   sum   : result
//   carry : carry out of the top bit
//   zero  : sum == 0
// -----------------------------------------------------------------------------
module sap_alu
  import sap_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] sum,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   full;

  // Subtraction reuses the adder: invert B and inject sub as carry-in.
  assign b_eff = sub ? ~b : b;
  assign full  = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub};
  assign sum   = full[DATA_W-1:0];
  assign carry = full[DATA_W];
  assign zero  = (full[DATA_W-1:0] == '0);

endmodule

// File: rtl/sap_datapath.sv
// -----------------------------------------------------------------------------
// sap_datapath
// Datapath of the 8-bit accumulator CPU: shared bus mux, PC, MAR, RAM, IR,
// A/B registers, ALU, carry/zero flags and output register.
//   clk : clock, all state updates on the rising edge
//   clr : asynchronous active-low reset (RAM contents are kept)
//   dp  : sap_datapath_if slave (control word, program-load port, status)
// -----------------------------------------------------------------------------
module sap_datapath
  import sap_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic          clk,
  input  logic          clr,
  sap_datapath_if.slave dp
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [DATA_W-1:0] out_reg;
  logic              flag_c_reg;
  logic              flag_z_reg;
  logic              strobe_reg;
  logic              halted_reg;
  logic              err_reg;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_rd;

  logic [DATA_W-1:0] alu_sum;
  logic              alu_c;
  logic              alu_z;

  logic [DATA_W-1:0] ir_ext;
  logic [DATA_W-1:0] pc_ext;
  bus_src_t          bus_src;
  logic [DATA_W-1:0] bus;

  logic [15:0]       c;
  logic              run;

  assign c = dp.ctrl;

  // Control bits only act when no load is in progress, the CPU is not
  // halted and this is not the halting cycle itself.
  assign run = !dp.ld_en && !halted_reg && !c[CTRL_HLT];

  assign ram_rd = mem[mar];
  assign ir_ext = {{(DATA_W-ADDR_W){1'b0}}, ir[ADDR_W-1:0]};
  assign pc_ext = {{(DATA_W-ADDR_W){1'b0}}, pc};

  sap_alu #(.DATA_W(DATA_W)) u_alu (
    .a     (a_reg),
    .b     (b_reg),
    .sub   (c[CTRL_SUB]),
    .sum   (alu_sum),
    .carry (alu_c),
    .zero  (alu_z)
  );

  // Priority bus mux; with contention the highest-priority source still
  // drives, the error is only recorded.
  always_comb begin
    bus_src = SRC_NONE;
    if (c[CTRL_RAMOA])         bus_src = SRC_RAM;
    else if (c[CTRL_INREGOA])  bus_src = SRC_IR;
    else if (c[CTRL_AOA])      bus_src = SRC_A;
    else if (c[CTRL_SUMOUT])   bus_src = SRC_ALU;
    else if (c[CTRL_PCOE])     bus_src = SRC_PC;

    bus = '0;
    case (bus_src)
      SRC_RAM: bus = ram_rd;
      SRC_IR:  bus = ir_ext;
      SRC_A:   bus = a_reg;
      SRC_ALU: bus = alu_sum;
      SRC_PC:  bus = pc_ext;
      default: bus = '0;
    endcase
  end

  // Register file, flags and status. Every writer samples the pre-edge bus,
  // so loop-backs such as sumout+awa are well defined.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc         <= '0;
      mar        <= '0;
      ir         <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      out_reg    <= '0;
      flag_c_reg <= 1'b0;
      flag_z_reg <= 1'b0;
      strobe_reg <= 1'b0;
      halted_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      strobe_reg <= run && c[CTRL_OUTREGWA];

      if (!dp.ld_en && !halted_reg && c[CTRL_HLT])
        halted_reg <= 1'b1;

      if (run) begin
        if (driver_count(c) > 3'd1)  err_reg <= 1'b1;
        if (c[CTRL_MARWA])           mar     <= bus[ADDR_W-1:0];
        if (c[CTRL_INREGWA])         ir      <= bus;
        if (c[CTRL_AWA])             a_reg   <= bus;
        if (c[CTRL_BWA])             b_reg   <= bus;
        if (c[CTRL_OUTREGWA])        out_reg <= bus;
        if (c[CTRL_PCJMP])           pc      <= bus[ADDR_W-1:0];
        else if (c[CTRL_PCINC])      pc      <= pc + 1'b1;
        if (c[CTRL_FLAGSIN]) begin
          flag_c_reg <= alu_c;
          flag_z_reg <= alu_z;
        end
      end
    end
  end

  // RAM has no reset so a loaded program survives clr; writes are still
  // suppressed while clr is low so a reset aborts them too.
  always_ff @(posedge clk) begin
    if (clr) begin
      if (dp.ld_en)
        mem[dp.ld_addr] <= dp.ld_data;
      else if (run && c[CTRL_RAMWA])
        mem[mar] <= bus;
    end
  end

  assign dp.ir_op      = ir[DATA_W-1 -: 4];
  assign dp.flag_c     = flag_c_reg;
  assign dp.flag_z     = flag_z_reg;
  assign dp.out_val    = out_reg;
  assign dp.out_strobe = strobe_reg;
  assign dp.halted     = halted_reg;
  assign dp.bus_err    = err_reg;
  assign dp.bus_dbg    = bus;

endmodule

// File: tb/tb_sap_datapath.sv
// -----------------------------------------------------------------------------
// tb_sap_datapath
// Self-checking bench for sap_datapath. Values expected on the output
// register are queued when the driving step is issued and compared when
// out_strobe appears.
// -----------------------------------------------------------------------------
module tb_sap_datapath;
  import sap_pkg::*;

  typedef struct {
    logic [7:0] val;
    logic       c;
    logic       z;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] s;
    logic       c;
    logic       z;
  } alu_vec_t;

  logic clk = 1'b0;
  logic clr;
  int   total = 0;
  int   bad = 0;
  int   strobe_count = 0;
  int   s0;
  exp_t exp_q[$];
  alu_vec_t vecs[10];
  logic [15:0] prog[15];

  sap_datapath_if dp_if ();

  sap_datapath dut (
    .clk (clk),
    .clr (clr),
    .dp  (dp_if)
  );

  always #5 clk = ~clk;

  // One comparison; records and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Drive one control word for one rising edge.
  task automatic applyStimulus(input logic [15:0] cw);
    dp_if.ctrl = cw;
    @(posedge clk);
    #1;
    dp_if.ctrl = '0;
  endtask

  task automatic loadWord(input logic [3:0] addr, input logic [7:0] data);
    dp_if.ld_en   = 1'b1;
    dp_if.ld_addr = addr;
    dp_if.ld_data = data;
    @(posedge clk);
    #1;
    dp_if.ld_en = 1'b0;
  endtask

  // Reset pulse placed between clock edges.
  task automatic pulseReset();
    #2 clr = 1'b0;
    #2 clr = 1'b1;
  endtask

  // A and B are written through RAM[0], relying on MAR == 0.
  task automatic setA(input logic [7:0] v);
    loadWord(4'd0, v);
    applyStimulus(16'h1200);
  endtask

  task automatic setB(input logic [7:0] v);
    loadWord(4'd0, v);
    applyStimulus(16'h1020);
  endtask

  task automatic expectOut(input logic [7:0] v, input logic c, input logic z);
    exp_t e;
    e.val = v;
    e.c = c;
    e.z = z;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    repeat (2) @(posedge clk);
    #1;
    checkOutput({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ir_op"}, dp_if.ir_op, 0);
    checkOutput({tag, "_flag_c"}, dp_if.flag_c, 0);
    checkOutput({tag, "_flag_z"}, dp_if.flag_z, 0);
    checkOutput({tag, "_out_val"}, dp_if.out_val, 0);
    checkOutput({tag, "_out_strobe"}, dp_if.out_strobe, 0);
    checkOutput({tag, "_halted"}, dp_if.halted, 0);
    checkOutput({tag, "_bus_err"}, dp_if.bus_err, 0);
    checkOutput({tag, "_bus_dbg"}, dp_if.bus_dbg, 0);
  endtask

  // Scoreboard: every strobe pops one expected output-register value.
  always @(negedge clk) begin
    exp_t e;
    if (dp_if.out_strobe === 1'b1) begin
      strobe_count++;
      if (exp_q.size() == 0) begin
        checkOutput("strobe_when_idle", dp_if.out_strobe, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("sb_out_val", dp_if.out_val, e.val);
        checkOutput("sb_flag_c", dp_if.flag_c, e.c);
        checkOutput("sb_flag_z", dp_if.flag_z, e.z);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs = '{
      '{8'h1C, 8'h0E, 1'b0, 8'h2A, 1'b0, 1'b0},
      '{8'h05, 8'h05, 1'b0, 8'h0A, 1'b0, 1'b0},
      '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1},
      '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1},
      '{8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0},
      '{8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b1},
      '{8'h03, 8'h04, 1'b1, 8'hFF, 1'b0, 1'b0},
      '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1},
      '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0},
      '{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0}
    };
    prog = '{FETCH0, FETCH1, 16'h4800, 16'h1200,
             FETCH0, FETCH1, 16'h4800, 16'h1020, 16'h0281,
             FETCH0, FETCH1, 16'h0110,
             FETCH0, FETCH1, 16'h8000};

    dp_if.ctrl    = '0;
    dp_if.ld_en   = 1'b0;
    dp_if.ld_addr = '0;
    dp_if.ld_data = '0;
    clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("power_on");
    #3 clr = 1'b1;
    @(posedge clk);
    #1;

    // ALU vectors: A, B, execute with flagsin, then OUT of A.
    for (int i = 0; i < 10; i++) begin
      setA(vecs[i].a);
      setB(vecs[i].b);
      expectOut(vecs[i].s, vecs[i].c, vecs[i].z);
      applyStimulus(vecs[i].sub ? 16'h02C1 : 16'h0281);
      applyStimulus(16'h0110);
    end
    drain("alu");

    // Asynchronous reset mid-run clears every output.
    #2 clr = 1'b0;
    #1 checkAllZero("midrun_reset");
    #1 clr = 1'b1;
    @(posedge clk);
    #1;

    // RAM contents survive a reset pulse.
    loadWord(4'd3, 8'h5A);
    pulseReset();
    loadWord(4'd0, 8'h03);
    applyStimulus(16'h5000);
    expectOut(8'h5A, 1'b0, 1'b0);
    applyStimulus(16'h1010);
    drain("ram_keep");

    // Small program: LDA 14, ADD 15, OUT, HLT.
    pulseReset();
    loadWord(4'd0, 8'h1E);
    loadWord(4'd1, 8'h2F);
    loadWord(4'd2, 8'hE0);
    loadWord(4'd3, 8'hF0);
    loadWord(4'd14, 8'h1C);
    loadWord(4'd15, 8'h0E);
    s0 = strobe_count;
    for (int i = 0; i < 15; i++) begin
      if (prog[i] == 16'h0110) expectOut(8'h2A, 1'b0, 1'b0);
      applyStimulus(prog[i]);
    end
    drain("prog");
    checkOutput("prog_out_val", dp_if.out_val, 8'h2A);
    checkOutput("prog_strobes", strobe_count - s0, 1);
    checkOutput("prog_flag_c", dp_if.flag_c, 0);
    checkOutput("prog_flag_z", dp_if.flag_z, 0);
    checkOutput("prog_halted", dp_if.halted, 1);
    checkOutput("prog_ir_op", dp_if.ir_op, OP_HLT);

    // PC wrap and jump-over-increment priority.
    pulseReset();
    repeat (15) applyStimulus(16'h0008);
    expectOut(8'h0F, 1'b0, 1'b0);
    applyStimulus(16'h0014);
    applyStimulus(16'h0008);
    expectOut(8'h00, 1'b0, 1'b0);
    applyStimulus(16'h0014);
    setA(8'h07);
    applyStimulus(16'h010A);
    expectOut(8'h07, 1'b0, 1'b0);
    applyStimulus(16'h0014);
    drain("pc");

    // Bus contention: RAM wins, error is sticky.
    pulseReset();
    setA(8'h22);
    loadWord(4'd0, 8'h11);
    dp_if.ctrl = 16'h1100;
    #1;
    checkOutput("contention_bus_dbg", dp_if.bus_dbg, 8'h11);
    checkOutput("contention_err_before", dp_if.bus_err, 0);
    @(posedge clk);
    #1;
    dp_if.ctrl = '0;
    #1;
    checkOutput("contention_err_set", dp_if.bus_err, 1);
    checkOutput("contention_bus_idle", dp_if.bus_dbg, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("contention_err_sticky", dp_if.bus_err, 1);

    // Halt: same-cycle write ignored, later writes ignored, load still works.
    pulseReset();
    setA(8'h44);
    loadWord(4'd0, 8'h33);
    s0 = strobe_count;
    applyStimulus(16'h9200);
    checkOutput("halt_set", dp_if.halted, 1);
    applyStimulus(16'h0110);
    applyStimulus(16'h1200);
    dp_if.ctrl = 16'h0100;
    #1;
    checkOutput("halt_a_kept", dp_if.bus_dbg, 8'h44);
    dp_if.ctrl = '0;
    checkOutput("halt_out_val", dp_if.out_val, 0);
    checkOutput("halt_no_strobe", strobe_count - s0, 0);
    loadWord(4'd2, 8'h77);
    checkOutput("halt_still", dp_if.halted, 1);
    pulseReset();
    checkOutput("halt_cleared", dp_if.halted, 0);
    loadWord(4'd0, 8'h02);
    applyStimulus(16'h5000);
    expectOut(8'h77, 1'b0, 1'b0);
    applyStimulus(16'h1010);
    drain("halt_load");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sap_datapath.md
# sap_datapath

Datapath for the 8-bit accumulator CPU, responding to the 16-bit control word produced each step by the control unit. It owns the shared 8-bit bus, program counter, memory address register, 16×8 RAM, instruction register, A/B registers, ALU, carry/zero flags and output register. It returns the opcode nibble and both flags so the control unit can build its next decode input. A program-load port fills RAM while the CPU is held idle.

## Interface
Parameters:
- `DATA_W`, default 8: bus, register and RAM word width.
- `ADDR_W`, default 4: PC, MAR and operand width. RAM depth is 2^ADDR_W.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `clr` in 1: asynchronous, active-low reset.
- `ctrl` in 16: control word in the control unit's bit order. Bits are hlt[15], marwa[14], ramwa[13], ramoa[12], inregoa[11], inregwa[10], awa[9], aoa[8], sumout[7], sub[6], bwa[5], outregwa[4], pcinc[3], pcoe[2], pcjmp[1], flagsin[0].
- `ld_en` in 1: program-load enable.
- `ld_addr` in ADDR_W: program-load address.
- `ld_data` in DATA_W: program-load data.
- `ir_op` out 4: IR[7:4], the opcode sent to the control unit.
- `flag_c` out 1: latched carry flag.
- `flag_z` out 1: latched zero flag.
- `out_val` out DATA_W: output register.
- `out_strobe` out 1: one-cycle pulse after each output-register write.
- `halted` out 1: sticky halt indicator.
- `bus_err` out 1: sticky bus-contention indicator.
- `bus_dbg` out DATA_W: current bus value.

## Operation
- **Bus (combinational mux, no tristates).**
  - Driver priority: ramoa > inregoa > aoa > sumout > pcoe.
  - inregoa drives {0, IR[3:0]}. pcoe drives {0, PC}.
  - With no driver asserted, the bus is 0x00.
  - Two or more drivers asserted in one cycle sets `bus_err` (sticky until reset). The priority winner still drives the bus.
- **Writers.** Each samples the bus at the rising edge:
  - marwa: MAR ← bus[ADDR_W-1:0].
  - ramwa: RAM[MAR] ← bus.
  - inregwa: IR ← bus.
  - awa: A ← bus.
  - bwa: B ← bus.
  - outregwa: out_val ← bus, and out_strobe=1 on the next cycle.
  - pcjmp: PC ← bus[ADDR_W-1:0].
  - Loop-back is legal and uses the pre-edge value, e.g. aoa+awa leaves A unchanged; sumout+awa gives A ← A±B.
- **PC.** pcinc adds 1 modulo 2^ADDR_W (0xF → 0x0). If pcjmp and pcinc are both asserted, pcjmp wins.
- **ALU** (combinational):
  - Add: {c, s} = A + B.
  - Sub: {c, s} = A + ~B + 1, so c=1 means no borrow.
  - z = (s == 0).
  - flagsin latches c and z. Flags are unchanged otherwise.
- **Halt.**
  - hlt=1 sets `halted` on that edge.
  - All other bits in the same cycle are ignored.
  - While `halted`=1, no register or RAM updates occur. Only `clr` clears it.
- **Program load.**
  - ld_en=1: RAM[ld_addr] ← ld_data at each edge.
  - All `ctrl` bits are ignored during load, including hlt. `bus_err` is not evaluated.
  - ld_en is honoured even when `halted`=1.
- **Reset (clr low, asynchronous).**
  - PC, MAR, IR, A, B, out_val, flags, out_strobe, halted and bus_err all go to 0.
  - RAM is not reset; contents survive reset.
  - Reset asserted mid-instruction aborts all pending writes that cycle.

## Timing
- All writes become visible one cycle after the edge that samples `ctrl`.
- `ir_op`, `flag_c` and `flag_z` are registered outputs.
- `bus_dbg` is combinational from `ctrl` and register state.
- Fetch takes two cycles:
  - Step 0, ctrl=0x4004: MAR ← PC.
  - Step 1, ctrl=0x1408: IR ← RAM[MAR] and PC+1. `ir_op` is valid from the following cycle.
- RAM read is asynchronous within the cycle, addressed by MAR.
- The ADD execute step, ctrl=0x0281, writes A and the flags on the same edge. The flags reflect the pre-edge A+B.
- out_strobe goes high the cycle after the outregwa edge and lasts exactly one cycle. Back-to-back outregwa cycles give a continuous strobe.

## Structure
- Shared package `sap_pkg`:
  - control-bit index constants (HLT=15 … FLAGSIN=0);
  - named fetch words FETCH0=0x4004 and FETCH1=0x1408;
  - opcode constants (LDA=1, ADD=2, SUB=3, STA=4, LDI=5, JMP=6, JC=7, JZ=8, OUT=14, HLT=15).
- One sub-module `sap_alu`: DATA_W add/sub with carry and zero outputs, purely combinational.
- Registers, bus mux and RAM live in `sap_datapath`.

## Test plan
- **Reset:** drive clr low mid-run → every output 0. Then preload RAM[3]=0x5A, pulse clr → RAM[3] still reads 0x5A.
- **Program:** load RAM[0..3]={0x1E, 0x2F, 0xE0, 0xF0}, RAM[14]=0x1C, RAM[15]=0x0E, then drive the control unit's sequence → out_val=0x2A, one out_strobe, flag_c=0, flag_z=0, halted=1.
- **Subtract:** A=0x05, B=0x05 with ctrl=0x02C1 → A=0x00, flag_z=1, flag_c=1. Then A=0x03, B=0x04 → A=0xFF, flag_c=0, flag_z=0.
- **PC boundaries:** PC=0xF with pcinc → PC=0x0. Bus=0x07 with pcinc+pcjmp+aoa (A=0x07) → PC=0x7.
- **Contention:** ramoa+aoa asserted together with RAM[MAR]=0x11, A=0x22 → bus_dbg=0x11, bus_err=1 and stays 1 after ctrl returns to 0.
- **Halt:** hlt together with awa (bus=0x33) → A unchanged, halted=1. Later writes are ignored. ld_en write to RAM[2]=0x77 still lands.
